// File: rtl/axi_rd_sram_bridge.sv
// axi_rd_sram_bridge: AXI4 read-only slave serving bursts from a 1-cycle SRAM.
// Optional counters: define AXI_RD_SRAM_PERF_EN for perf_beats_o/perf_stall_o.
module axi_rd_sram_bridge #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 11,
  parameter int MEM_WORDS      = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AXI_ID_WIDTH-1:0]       ar_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     ar_araddr,
  input  logic [7:0]                    ar_arlen,
  input  logic [2:0]                    ar_arsize,
  input  logic [1:0]                    ar_arburst,
  input  logic                          ar_arvalid,
  output logic                          ar_arready,
  output logic [AXI_ID_WIDTH-1:0]       r_rid,
  output logic [AXI_DATA_WIDTH-1:0]     r_rdata,
  output logic [1:0]                    r_rresp,
  output logic                          r_rlast,
  output logic                          r_rvalid,
  input  logic                          r_rready,
  output logic                          sram_req_o,
  output logic [$clog2(MEM_WORDS)-1:0]  sram_addr_o,
  input  logic [AXI_DATA_WIDTH-1:0]     sram_rdata_i
`ifdef AXI_RD_SRAM_PERF_EN
  ,
  output logic [31:0]                   perf_beats_o,
  output logic [31:0]                   perf_stall_o
`endif
);

  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int DW   = AXI_DATA_WIDTH;
  localparam int IW   = AXI_ID_WIDTH;
  localparam int OFFW = $clog2(DW / 8);
  localparam int MAW  = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] MEM_BYTES = AW'(MEM_WORDS) * AW'(DW / 8);

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_SLV   = 2'b10;
  localparam logic [1:0] R_DEC   = 2'b11;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, ERR} state_t;

  state_t         state;
  logic [IW-1:0]  id_q;
  logic [AW-1:0]  addr_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [7:0]     left_q;
  logic           iss_done;
  logic           rdy_q;

  logic           infl_q;
  logic [1:0]     infl_resp;
  logic           infl_last;

  logic [DW-1:0]  f_data [2];
  logic [1:0]     f_resp [2];
  logic           f_last [2];
  logic           wp;
  logic           rp;
  logic [1:0]     cnt;

  logic           pop;
  logic [2:0]     occ;
  logic           credit;
  logic           active;
  logic           issue;
  logic           oob;
  logic           bad_req;
  logic [AW-1:0]  step;

  assign ar_arready = rdy_q;
  assign r_rvalid   = (cnt != 2'd0);
  assign r_rid      = id_q;
  assign r_rdata    = f_data[rp];
  assign r_rresp    = f_resp[rp];
  assign r_rlast    = f_last[rp];

  assign pop    = r_rvalid & r_rready;
  assign occ    = {1'b0, cnt} + {2'b0, infl_q} - {2'b0, pop};
  assign credit = (occ < 3'd2);
  assign active = (state == BURST) | ((state == ERR) & ~iss_done);
  assign issue  = active & credit;
  assign oob    = (addr_q >= MEM_BYTES);
  assign step   = AW'(1) << size_q;

  assign sram_req_o  = issue & (state == BURST) & ~oob;
  assign sram_addr_o = addr_q[OFFW +: MAW];

  assign bad_req = (ar_arburst == 2'b10) | (ar_arburst == 2'b11) |
                   (ar_arsize > 3'(OFFW));

  // Burst FSM, issue pipeline and 2-entry response FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      left_q    <= '0;
      iss_done  <= 1'b0;
      rdy_q     <= 1'b0;
      infl_q    <= 1'b0;
      infl_resp <= R_OKAY;
      infl_last <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_resp[i] <= R_OKAY;
        f_last[i] <= 1'b0;
      end
    end else begin
      if (infl_q) begin
        f_data[wp] <= (infl_resp == R_OKAY) ? sram_rdata_i : '0;
        f_resp[wp] <= infl_resp;
        f_last[wp] <= infl_last;
        wp         <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, infl_q} - {1'b0, pop};

      infl_q <= issue;
      if (issue) begin
        infl_resp <= (state == ERR) ? R_SLV :
                     oob ? R_DEC : R_OKAY;
        infl_last <= (left_q == 8'd0);
        left_q    <= left_q - 8'd1;
        if (burst_q == B_INCR) addr_q <= addr_q + step;
      end

      unique case (state)
        IDLE: begin
          if (rdy_q & ar_arvalid) begin
            id_q     <= ar_arid;
            addr_q   <= ar_araddr;
            size_q   <= ar_arsize;
            burst_q  <= ar_arburst;
            left_q   <= ar_arlen;
            iss_done <= 1'b0;
            rdy_q    <= 1'b0;
            state    <= bad_req ? ERR : BURST;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        BURST: begin
          if (issue && left_q == 8'd0) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && r_rlast) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        ERR: begin
          if (issue && left_q == 8'd0) iss_done <= 1'b1;
          if (pop && r_rlast) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (burst_q == B_FIXED && 1'b0) addr_q <= addr_q;
    end
  end

`ifdef AXI_RD_SRAM_PERF_EN
  // Saturating counters of R handshakes and R stall cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_beats_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pop && perf_beats_o != 32'hFFFF_FFFF)
        perf_beats_o <= perf_beats_o + 32'd1;
      if (r_rvalid && !r_rready && perf_stall_o != 32'hFFFF_FFFF)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
